// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states
// and the control value presented while the stage holds no entry.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  // Wide enough for any control bundle; users slice it down to CTRL_W.
  localparam int CTRL_MAX_W = 256;
  localparam logic [CTRL_MAX_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module pipe_stage_skid_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc_i && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE_W = CTRL_BUBBLE[CTRL_W-1:0];

  stage_state_e      state_reg, state_next;
  logic              in_ready_reg;
  logic [DATA_W-1:0] main_data_reg, skid_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg, skid_ctrl_reg;

  logic main_valid;
  logic acc, ret;
  logic load_main_in, load_main_skid, load_skid;

  assign main_valid = (state_reg != ST_EMPTY);
  assign acc        = in_valid_i & in_ready_reg;
  assign ret        = main_valid & out_ready_i;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (acc) begin
            state_next   = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (acc && ret) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_next = ST_SKID;
            load_skid  = 1'b1;
          end else if (ret) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the skid can move forward.
          if (ret) begin
            state_next     = ST_FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_SKID);
      if (load_main_in) begin
        main_data_reg <= in_data_i;
        main_ctrl_reg <= in_ctrl_i;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_ctrl_reg <= skid_ctrl_reg;
      end
      if (load_skid) begin
        skid_data_reg <= in_data_i;
        skid_ctrl_reg <= in_ctrl_i;
      end
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_data_reg;

  // Downstream must never see stale write enables from an empty stage.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi = gi + 1) begin : g_ctrl_gate
      assign out_ctrl_o[gi] = main_valid ? main_ctrl_reg[gi] : CTRL_BUBBLE_W[gi];
    end
  endgenerate

  pipe_stage_skid_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (main_valid & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a FIFO-occupancy model.
module tb_pipe_stage_skid;

  localparam int DATA_W  = 128;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i = '0;
  logic [CTRL_W-1:0] in_ctrl_i = '0;
  logic              flush_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_ctrl_i  (in_ctrl_i),
    .flush_i    (flush_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_ctrl_o (out_ctrl_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: the stage is a FIFO of depth 2; the head is what is presented.
  ent_t q[$];
  int   model_cnt = 0;
  int   n_assert  = 0;
  int   n_fail    = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic v;
    v = (q.size() > 0);
    chk({tag, ".out_valid"}, out_valid_o, v);
    chk({tag, ".in_ready"}, in_ready_o, (q.size() < 2));
    chk({tag, ".stall_cnt"}, stall_cnt_o, model_cnt);
    if (v) begin
      chk({tag, ".out_data"}, out_data_o, q[0].d);
      chk({tag, ".out_ctrl"}, out_ctrl_o, q[0].c);
    end else begin
      chk({tag, ".out_ctrl_bubble"}, out_ctrl_o, '0);
    end
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic rdy, input logic fl);
    logic acc, ret, stall;
    in_valid_i  = v;
    in_data_i   = d;
    in_ctrl_i   = c;
    out_ready_i = rdy;
    flush_i     = fl;
    acc   = v && (q.size() < 2);
    ret   = (q.size() > 0) && rdy;
    stall = (q.size() > 0) && !rdy;
    @(posedge clk_i);
    if (stall && model_cnt < CNT_MAX) model_cnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back('{d: d, c: c});
    end
    @(negedge clk_i);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk({tag, ".async_valid"}, out_valid_o, 1'b0);
    chk({tag, ".async_ready"}, in_ready_o, 1'b1);
    chk({tag, ".async_ctrl"}, out_ctrl_o, '0);
    chk({tag, ".async_cnt"}, stall_cnt_o, '0);
    q.delete();
    model_cnt = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk({tag, ".data_zero"}, out_data_o, '0);
    check_all(tag);
  endtask

  initial begin
    int idx;
    int seen;
    int ready_low;
    logic stalled;
    logic [DATA_W-1:0] pres[$];
    logic [DATA_W-1:0] exp_pres[5];

    #1;
    @(negedge clk_i);
    do_reset("rst0");

    // Mid-stream reset while both entries are occupied
    cycle("fill", 1'b1, 128'hA1, 8'h11, 1'b0, 1'b0);
    cycle("fill", 1'b1, 128'hA2, 8'h22, 1'b0, 1'b0);
    chk("skid_ready_low", in_ready_o, 1'b0);
    do_reset("rst_mid");

    // Full-rate streaming
    pres.delete();
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
      if (out_valid_o) pres.push_back(out_data_o);
    end
    cycle("stream_tail", 1'b0, '0, '0, 1'b1, 1'b0);
    if (out_valid_o) pres.push_back(out_data_o);
    chk("stream_count", pres.size(), 8);
    for (int i = 0; i < pres.size(); i++) chk("stream_order", pres[i], DATA_W'(i + 1));

    // One-cycle back-pressure while data 2 is presented
    idx = 1; stalled = 1'b0; ready_low = 0; seen = 0;
    pres.delete();
    exp_pres[0] = 1; exp_pres[1] = 2; exp_pres[2] = 2; exp_pres[3] = 3; exp_pres[4] = 4;
    for (int cyc = 0; cyc < 20 && (idx <= 4 || q.size() > 0); cyc++) begin
      logic rdy, v;
      int cur;
      v   = (idx <= 4);
      cur = idx;
      rdy = 1'b1;
      if (q.size() > 0 && q[0].d == 2 && !stalled) begin
        rdy = 1'b0;
        stalled = 1'b1;
      end
      if (v && q.size() < 2) idx++;
      cycle("bp", v, DATA_W'(cur), 8'h5A, rdy, 1'b0);
      if (!in_ready_o) ready_low++;
      if (out_valid_o) pres.push_back(out_data_o);
    end
    chk("bp_count", pres.size(), 5);
    for (int i = 0; i < 5 && i < pres.size(); i++) chk("bp_seq", pres[i], exp_pres[i]);
    chk("bp_ready_low", ready_low, 1);
    chk("bp_stall_cnt", stall_cnt_o, 1);

    // Flush from SKID, with C offered in the flush cycle
    do_reset("rst_fl");
    cycle("fl_a", 1'b1, 128'hA, 8'hFF, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 128'hB, 8'hFF, 1'b0, 1'b0);
    cycle("fl_pulse", 1'b1, 128'hC, 8'hFF, 1'b0, 1'b1);
    chk("fl_valid", out_valid_o, 1'b0);
    chk("fl_ctrl", out_ctrl_o, 8'h00);
    chk("fl_ready", in_ready_o, 1'b1);
    for (int i = 0; i < 3; i++) cycle("fl_drain", 1'b0, '0, '0, 1'b1, 1'b0);
    // Flush while ready is high: the offered entry must still be dropped
    cycle("fl_d", 1'b1, 128'hD, 8'h81, 1'b0, 1'b0);
    cycle("fl_e", 1'b1, 128'hE, 8'h82, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle("fl_hold", 1'b1, 128'hF0 + DATA_W'(i), 8'h83, 1'b1, 1'b1);
    cycle("fl_after", 1'b0, '0, '0, 1'b1, 1'b0);

    // Counter saturation, unaffected by flush
    do_reset("rst_sat");
    cycle("sat_load", 1'b1, 128'h55, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle("sat", 1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_255", stall_cnt_o, 255);
    cycle("sat_flush", 1'b0, '0, '0, 1'b0, 1'b1);
    cycle("sat_post", 1'b1, 128'h66, 8'h02, 1'b1, 1'b0);
    chk("sat_keep", stall_cnt_o, 255);

    // Random traffic
    do_reset("rst_rnd");
    for (int i = 0; i < 10000; i++) begin
      logic v, rdy, fl;
      v   = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) < 2);
      cycle("rnd", v, {$urandom, $urandom, $urandom, $urandom}, CTRL_W'($urandom), rdy, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
